alu_op_sequencer: RTL and testbench

//  Command-driven sequencer for the 8-bit zx/nx/zy/ny/f/no ALU. Accepts one op per valid/ready

---
 rtl/alu_seq_pkg.sv | 45 ++++
 rtl/alu_op_sequencer_if.sv | 30 +++
 rtl/alu_ctrl_decode.sv | 40 ++++
 rtl/alu_op_sequencer.sv | 165 ++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared definitions for the ALU op sequencer.
//   - opcode values (4-bit)
//   - 6-bit {zx,nx,zy,ny,f,no} control encodings
//   - FSM state type
//   - CTRL_QUIET: control word driven whenever the ALU is not in use
package alu_seq_pkg;

   localparam logic [3:0] OP_ZERO = 4'd0;
   localparam logic [3:0] OP_ONE  = 4'd1;
   localparam logic [3:0] OP_NEG1 = 4'd2;
   localparam logic [3:0] OP_X    = 4'd3;
   localparam logic [3:0] OP_Y    = 4'd4;
   localparam logic [3:0] OP_NOTX = 4'd5;
   localparam logic [3:0] OP_NEGX = 4'd6;
   localparam logic [3:0] OP_INCX = 4'd7;
   localparam logic [3:0] OP_DECX = 4'd8;
   localparam logic [3:0] OP_ADD  = 4'd9;
   localparam logic [3:0] OP_SUB  = 4'd10;
   localparam logic [3:0] OP_AND  = 4'd11;
   localparam logic [3:0] OP_OR   = 4'd12;
   localparam logic [3:0] OP_MUL  = 4'd13;

   localparam logic [5:0] CTRL_ZERO  = 6'b101010;
   localparam logic [5:0] CTRL_ONE   = 6'b111111;
   localparam logic [5:0] CTRL_NEG1  = 6'b111010;
   localparam logic [5:0] CTRL_X     = 6'b001100;
   localparam logic [5:0] CTRL_Y     = 6'b110000;
   localparam logic [5:0] CTRL_NOTX  = 6'b001101;
   localparam logic [5:0] CTRL_NEGX  = 6'b001111;
   localparam logic [5:0] CTRL_INCX  = 6'b011111;
   localparam logic [5:0] CTRL_DECX  = 6'b001110;
   localparam logic [5:0] CTRL_ADD   = 6'b000010;
   localparam logic [5:0] CTRL_SUB   = 6'b010011;
   localparam logic [5:0] CTRL_AND   = 6'b000000;
   localparam logic [5:0] CTRL_OR    = 6'b010101;
   localparam logic [5:0] CTRL_QUIET = 6'b101010;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_MUL  = 2'd2,
      ST_RESP = 2'd3
   } seq_state_t;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: command and response channels of the ALU op sequencer.
//   cmd_valid/cmd_ready/cmd_op/cmd_a/cmd_b : command channel (decoder -> sequencer)
//   rsp_valid/rsp_ready/rsp_data/rsp_zr/rsp_ng/rsp_err : response channel
//   modport master : decoder side; modport slave : sequencer side
interface alu_op_sequencer_if #(
   parameter int WIDTH = 8,
   parameter int OPW   = 4
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [OPW-1:0]   cmd_op;
   logic [WIDTH-1:0] cmd_a;
   logic [WIDTH-1:0] cmd_b;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_data;
   logic             rsp_zr;
   logic             rsp_ng;
   logic             rsp_err;

   modport master (
      output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_data, rsp_zr, rsp_ng, rsp_err
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
      output cmd_ready, rsp_valid, rsp_data, rsp_zr, rsp_ng, rsp_err
   );
endinterface

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: combinational opcode -> ALU control decode.
//   op    in  OPW  opcode
//   ctrl  out 6    {zx,nx,zy,ny,f,no}; MUL maps to ADD, illegal maps to quiet
//   legal out 1    opcode 0..13
module alu_ctrl_decode
   import alu_seq_pkg::*;
#(
   parameter int OPW = 4
) (
   input  logic [OPW-1:0] op,
   output logic [5:0]     ctrl,
   output logic           legal
);

   always_comb begin
      ctrl  = CTRL_QUIET;
      legal = 1'b1;
      case (op)
         OPW'(OP_ZERO): ctrl = CTRL_ZERO;
         OPW'(OP_ONE):  ctrl = CTRL_ONE;
         OPW'(OP_NEG1): ctrl = CTRL_NEG1;
         OPW'(OP_X):    ctrl = CTRL_X;
         OPW'(OP_Y):    ctrl = CTRL_Y;
         OPW'(OP_NOTX): ctrl = CTRL_NOTX;
         OPW'(OP_NEGX): ctrl = CTRL_NEGX;
         OPW'(OP_INCX): ctrl = CTRL_INCX;
         OPW'(OP_DECX): ctrl = CTRL_DECX;
         OPW'(OP_ADD):  ctrl = CTRL_ADD;
         OPW'(OP_SUB):  ctrl = CTRL_SUB;
         OPW'(OP_AND):  ctrl = CTRL_AND;
         OPW'(OP_OR):   ctrl = CTRL_OR;
         OPW'(OP_MUL):  ctrl = CTRL_ADD;
         default: begin
            ctrl  = CTRL_QUIET;
            legal = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: command-driven sequencer for the 8-bit zx/nx/zy/ny/f/no ALU.
//   clk, rst_n       : clock, asynchronous active-low reset
//   bus (slave)      : cmd_* command channel in, rsp_* registered response channel out
//   alu_x/alu_y      : operands to the external ALU
//   alu_ctrl         : {zx,nx,zy,ny,f,no} to the external ALU
//   alu_o/zr/ng      : combinational ALU result and flags
// Single-pass ops take one EXEC cycle; MUL is shift-add through the ALU.
// Build option: `define MUL_EARLY_EXIT_EN to end MUL once the multiplier is exhausted.
module alu_op_sequencer
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int OPW   = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   alu_op_sequencer_if.slave  bus,
   output logic [WIDTH-1:0]   alu_x,
   output logic [WIDTH-1:0]   alu_y,
   output logic [5:0]         alu_ctrl,
   input  logic [WIDTH-1:0]   alu_o,
   input  logic               alu_zr,
   input  logic               alu_ng
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   seq_state_t       state_q, state_d;
   logic [OPW-1:0]   op_q;
   logic [WIDTH-1:0] m_q, n_q, acc_q;
   logic [CNT_W-1:0] cnt_q;
   logic             rsp_valid_q, rsp_zr_q, rsp_ng_q, rsp_err_q;
   logic [WIDTH-1:0] rsp_data_q;

   logic             cmd_ready_w, accept;
   logic [OPW-1:0]   dec_op;
   logic [5:0]       dec_ctrl;
   logic             dec_legal;
   logic [WIDTH-1:0] n_shift, acc_next;
   logic             mul_last;

   // One decoder serves both the incoming opcode (legality at accept) and the latched one.
   assign dec_op = (state_q == ST_IDLE) ? bus.cmd_op : op_q;

   alu_ctrl_decode #(.OPW(OPW)) u_dec (
      .op    (dec_op),
      .ctrl  (dec_ctrl),
      .legal (dec_legal)
   );

   assign cmd_ready_w   = (state_q == ST_IDLE);
   assign accept        = bus.cmd_valid && cmd_ready_w;
   assign bus.cmd_ready = cmd_ready_w;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_zr    = rsp_zr_q;
   assign bus.rsp_ng    = rsp_ng_q;
   assign bus.rsp_err   = rsp_err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      alu_x    = '0;
      alu_y    = '0;
      alu_ctrl = CTRL_QUIET;
      mul_last = 1'b0;
      n_shift  = n_q >> 1;
      acc_next = n_q[0] ? alu_o : acc_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (!dec_legal)                      state_d = ST_RESP;
               else if (bus.cmd_op == OPW'(OP_MUL)) state_d = ST_MUL;
               else                                 state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            alu_x    = m_q;
            alu_y    = n_q;
            alu_ctrl = dec_ctrl;
            state_d  = ST_RESP;
         end
         ST_MUL: begin
            alu_x    = acc_q;
            alu_y    = m_q;
            alu_ctrl = CTRL_ADD;
`ifdef MUL_EARLY_EXIT_EN
            // The count bound is redundant (n empties after WIDTH shifts) but keeps cnt meaningful.
            mul_last = (n_shift == '0) || (cnt_q == CNT_W'(WIDTH - 1));
`else
            mul_last = (cnt_q == CNT_W'(WIDTH - 1));
`endif
            if (mul_last) state_d = ST_RESP;
         end
         ST_RESP: begin
            if (bus.rsp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q        <= '0;
         m_q         <= '0;
         n_q         <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_zr_q    <= 1'b0;
         rsp_ng_q    <= 1'b0;
         rsp_err_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  op_q  <= bus.cmd_op;
                  m_q   <= bus.cmd_a;
                  n_q   <= bus.cmd_b;
                  acc_q <= '0;
                  cnt_q <= '0;
                  if (!dec_legal) begin
                     rsp_valid_q <= 1'b1;
                     rsp_data_q  <= '0;
                     rsp_zr_q    <= 1'b1;
                     rsp_ng_q    <= 1'b0;
                     rsp_err_q   <= 1'b1;
                  end
               end
            end
            ST_EXEC: begin
               rsp_valid_q <= 1'b1;
               rsp_data_q  <= alu_o;
               rsp_zr_q    <= alu_zr;
               rsp_ng_q    <= alu_ng;
               rsp_err_q   <= 1'b0;
            end
            ST_MUL: begin
               acc_q <= acc_next;
               m_q   <= m_q << 1;
               n_q   <= n_shift;
               cnt_q <= cnt_q + CNT_W'(1);
               // Flags come from the final accumulator, not the ALU, since the last add may be skipped.
               if (mul_last) begin
                  rsp_valid_q <= 1'b1;
                  rsp_data_q  <= acc_next;
                  rsp_zr_q    <= ~|acc_next;
                  rsp_ng_q    <= acc_next[WIDTH-1];
                  rsp_err_q   <= 1'b0;
               end
            end
            ST_RESP: begin
               if (bus.rsp_ready) rsp_valid_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed-vector bench for alu_op_sequencer with a behavioural ALU.
module tb_alu_op_sequencer;

`ifdef MUL_EARLY_EXIT_EN
   localparam int LAT_MUL_0C_0B = 5;
   localparam int LAT_MUL_10_10 = 6;
   localparam int LAT_MUL_07_02 = 3;
`else
   localparam int LAT_MUL_0C_0B = 9;
   localparam int LAT_MUL_10_10 = 9;
   localparam int LAT_MUL_07_02 = 9;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   alu_op_sequencer_if #(.WIDTH(8), .OPW(4)) bus ();

   logic [7:0] alu_x, alu_y, alu_o;
   logic [5:0] alu_ctrl;
   logic       alu_zr, alu_ng;

   alu_op_sequencer #(.WIDTH(8), .OPW(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .alu_x    (alu_x),
      .alu_y    (alu_y),
      .alu_ctrl (alu_ctrl),
      .alu_o    (alu_o),
      .alu_zr   (alu_zr),
      .alu_ng   (alu_ng)
   );

   // Behavioural zx/nx/zy/ny/f/no ALU
   logic [7:0] tx, ty, tr;
   always_comb begin
      tx = alu_ctrl[5] ? 8'h00 : alu_x;
      tx = alu_ctrl[4] ? ~tx : tx;
      ty = alu_ctrl[3] ? 8'h00 : alu_y;
      ty = alu_ctrl[2] ? ~ty : ty;
      tr = alu_ctrl[1] ? (tx + ty) : (tx & ty);
      tr = alu_ctrl[0] ? ~tr : tr;
   end
   assign alu_o  = tr;
   assign alu_zr = (tr == 8'h00);
   assign alu_ng = tr[7];

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic send(input string tag, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      @(negedge clk);
      check({tag, "_cmd_ready"}, bus.cmd_ready, 1);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_a     = a;
      bus.cmd_b     = b;
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
   endtask

   // Issues a command, measures latency from the accept edge, checks the response,
   // optionally stalls rsp_ready, then consumes the response.
   task automatic do_op(input string tag, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input int exp_lat, input logic [7:0] ed, input logic ez, input logic en,
                        input logic ee, input bit chk_zn, input int stall);
      int lat;
      send(tag, op, a, b);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!bus.rsp_valid && lat < 40);
      check({tag, "_lat"}, lat, exp_lat);
      check({tag, "_data"}, bus.rsp_data, ed);
      check({tag, "_err"}, bus.rsp_err, ee);
      if (chk_zn) begin
         check({tag, "_zr"}, bus.rsp_zr, ez);
         check({tag, "_ng"}, bus.rsp_ng, en);
      end
      check({tag, "_busy"}, bus.cmd_ready, 0);
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         check({tag, "_stall_valid"}, bus.rsp_valid, 1);
         check({tag, "_stall_data"}, bus.rsp_data, ed);
         check({tag, "_stall_busy"}, bus.cmd_ready, 0);
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b0;
      @(negedge clk);
      check({tag, "_consumed"}, bus.rsp_valid, 0);
      check({tag, "_ready_again"}, bus.cmd_ready, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      bit spurious;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = '0;
      bus.cmd_a     = '0;
      bus.cmd_b     = '0;
      bus.rsp_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_rsp_valid", bus.rsp_valid, 0);
      check("rst_rsp_data", bus.rsp_data, 8'h00);
      check("rst_rsp_err", bus.rsp_err, 0);
      check("rst_cmd_ready", bus.cmd_ready, 1);
      check("rst_alu_ctrl", alu_ctrl, 6'b101010);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_alu_ctrl", alu_ctrl, 6'b101010);
      check("idle_alu_x", alu_x, 8'h00);
      check("idle_alu_y", alu_y, 8'h00);

      //    tag       op     a      b      lat            data   zr    ng    err   zn stall
      do_op("add",    4'd9,  8'h05, 8'h03, 2,             8'h08, 1'b0, 1'b0, 1'b0, 1, 0);
      do_op("sub",    4'd10, 8'h03, 8'h05, 2,             8'hFE, 1'b0, 1'b1, 1'b0, 1, 0);
      do_op("negx",   4'd6,  8'h01, 8'h00, 2,             8'hFF, 1'b0, 1'b1, 1'b0, 1, 0);
      do_op("decx",   4'd8,  8'h00, 8'h00, 2,             8'hFF, 1'b0, 1'b1, 1'b0, 1, 0);
      do_op("zero",   4'd0,  8'h5A, 8'hA5, 2,             8'h00, 1'b1, 1'b0, 1'b0, 1, 0);
      do_op("one",    4'd1,  8'h5A, 8'hA5, 2,             8'h01, 1'b0, 1'b0, 1'b0, 1, 0);
      do_op("neg1",   4'd2,  8'h5A, 8'hA5, 2,             8'hFF, 1'b0, 1'b1, 1'b0, 1, 0);
      do_op("x",      4'd3,  8'h80, 8'h11, 2,             8'h80, 1'b0, 1'b1, 1'b0, 1, 0);
      do_op("y",      4'd4,  8'h80, 8'h7F, 2,             8'h7F, 1'b0, 1'b0, 1'b0, 1, 0);
      do_op("notx",   4'd5,  8'h0F, 8'h00, 2,             8'hF0, 1'b0, 1'b1, 1'b0, 1, 0);
      do_op("incx",   4'd7,  8'hFF, 8'h00, 2,             8'h00, 1'b1, 1'b0, 1'b0, 1, 0);
      do_op("and",    4'd11, 8'hF0, 8'h3C, 2,             8'h30, 1'b0, 1'b0, 1'b0, 1, 0);
      do_op("or",     4'd12, 8'hF0, 8'h3C, 2,             8'hFC, 1'b0, 1'b1, 1'b0, 1, 0);
      do_op("mul_84", 4'd13, 8'h0C, 8'h0B, LAT_MUL_0C_0B, 8'h84, 1'b0, 1'b1, 1'b0, 1, 0);
      do_op("mul_00", 4'd13, 8'h10, 8'h10, LAT_MUL_10_10, 8'h00, 1'b1, 1'b0, 1'b0, 1, 0);
      do_op("mul_0e", 4'd13, 8'h07, 8'h02, LAT_MUL_07_02, 8'h0E, 1'b0, 1'b0, 1'b0, 1, 0);
      do_op("stall",  4'd9,  8'h05, 8'h03, 2,             8'h08, 1'b0, 1'b0, 1'b0, 1, 5);
      do_op("ill14",  4'd14, 8'h12, 8'h34, 1,             8'h00, 1'b0, 1'b0, 1'b1, 0, 0);
      do_op("ill15",  4'd15, 8'h12, 8'h34, 1,             8'h00, 1'b0, 1'b0, 1'b1, 0, 0);
      do_op("post_ill", 4'd9, 8'h7F, 8'h01, 2,            8'h80, 1'b0, 1'b1, 1'b0, 1, 0);

      // Reset asserted in the middle of a MUL
      send("rst_mul", 4'd13, 8'h0C, 8'h0B);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_rsp_valid", bus.rsp_valid, 0);
      check("midrst_rsp_data", bus.rsp_data, 8'h00);
      check("midrst_rsp_zr", bus.rsp_zr, 0);
      check("midrst_rsp_ng", bus.rsp_ng, 0);
      check("midrst_rsp_err", bus.rsp_err, 0);
      check("midrst_cmd_ready", bus.cmd_ready, 1);
      check("midrst_alu_ctrl", alu_ctrl, 6'b101010);
      check("midrst_alu_x", alu_x, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      spurious = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (bus.rsp_valid) spurious = 1'b1;
      end
      check("midrst_no_spurious", spurious, 0);
      check("midrst_ready_after", bus.cmd_ready, 1);
      do_op("post_rst", 4'd10, 8'h10, 8'h01, 2, 8'h0F, 1'b0, 1'b0, 1'b0, 1, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
